// File: rtl/tick_scheduler.sv
// Programmable tick divider driving a 4-slot active-low scan select.
// New divisors offered while running are staged and applied on the next period wrap.
module tick_scheduler #(
  parameter int unsigned CNT_W   = 13,
  parameter int unsigned DEF_DIV = 4096
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_divisor,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             tick,
  output logic [1:0]       slot,
  output logic [3:0]       an_n,
  output logic             busy
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [1:0]       slot_q, slot_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer;
  logic             good;
  logic             wrap;

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign good      = xfer && (cfg_divisor != '0);
  assign wrap      = (cnt_q == (div_q - CNT_W'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    pend_d    = pend_q;
    slot_d    = slot_q;
    tick_d    = 1'b0;
    cfg_err_d = xfer && (cfg_divisor == '0);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (good) div_d = cfg_divisor;
        if (run) state_d = RUN;
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (good) div_d = cfg_divisor;
        end else begin
          if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            slot_d = slot_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Staged value waits for the next wrap, even if this edge wraps too.
          if (good) begin
            pend_d  = cfg_divisor;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
          div_d   = pend_q;
          pend_d  = '0;
        end else if (wrap) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          slot_d  = slot_q + 2'd1;
          div_d   = pend_q;
          pend_d  = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DEF_DIV_W;
      pend_q    <= '0;
      slot_q    <= '0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      slot_q    <= slot_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign cfg_err = cfg_err_q;
  assign slot    = slot_q;
  assign an_n    = busy ? ~(4'b0001 << slot_q) : 4'b1111;

endmodule
